// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter, with frame lock and watchdog
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       send,
  output logic [7:0]                 dintx,
  input  logic                       donetx,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] err_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      err_id_q, err_id_d;
  logic               last_q, last_d;
  logic               send_q, send_d;
  logic               timeout_err_q, timeout_err_d;
  logic [7:0]         dintx_q, dintx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]      wd_q, wd_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      owner_next;
  logic               xfer;
  logic               wd_expire;
  logic               done_ok;

  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= unsigned'(NUM_REQ)) s = s - unsigned'(NUM_REQ);
    return IW'(s);
  endfunction

  // First valid requester scanning upward from ptr with wraparound.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = idx_add(ptr_q, unsigned'(i));
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign wd_expire  = (state_q != S_IDLE) && (wd_q == WD_LAST);
  assign done_ok    = (state_q == S_WAIT) && donetx && !send_q;
  assign sel        = (state_q == S_HOLD) ? owner_q : win_idx;
  assign owner_next = idx_add(owner_q, 32'd1);

  // The owner is refused in its expiring HOLD cycle so an aborted grant never eats a byte.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state_q == S_IDLE && win_found) begin
        req_ready[win_idx] = 1'b1;
      end else if (state_q == S_HOLD && !wd_expire) begin
        req_ready[owner_q] = 1'b1;
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    err_id_d      = err_id_q;
    last_d        = last_q;
    send_d        = 1'b0;
    timeout_err_d = 1'b0;
    dintx_d       = dintx_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d          = S_WAIT;
          dintx_d          = req_data[8*sel +: 8];
          last_d           = req_last[sel];
          send_d           = 1'b1;
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          wd_d             = '0;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + CW'(1);
        if (done_ok) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = owner_next;
          end else begin
            state_d = S_HOLD;
            wd_d    = '0;
          end
        end else if (wd_expire) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          ptr_d         = owner_next;
          timeout_err_d = 1'b1;
          err_id_d      = owner_q;
        end
      end
      S_HOLD: begin
        wd_d = wd_q + CW'(1);
        if (xfer) begin
          state_d = S_WAIT;
          dintx_d = req_data[8*sel +: 8];
          last_d  = req_last[sel];
          send_d  = 1'b1;
          wd_d    = '0;
        end else if (wd_expire) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          ptr_d         = owner_next;
          timeout_err_d = 1'b1;
          err_id_d      = owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      err_id_q      <= '0;
      last_q        <= 1'b0;
      send_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      dintx_q       <= 8'h00;
      grant_q       <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      err_id_q      <= err_id_d;
      last_q        <= last_d;
      send_q        <= send_d;
      timeout_err_q <= timeout_err_d;
      dintx_q       <= dintx_d;
      grant_q       <= grant_d;
      wd_q          <= wd_d;
    end
  end

  assign send        = send_q;
  assign dintx       = dintx_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: vector tables, directed corner sequences and a
// randomized run checked against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           send;
  logic [7:0]     dintx;
  logic           donetx = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     err_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
  } arb_vec_t;

  typedef struct {
    logic [7:0]   data;
    logic [N-1:0] grant;
  } fair_vec_t;

  // Reference model state (0 idle, 1 byte in flight, 2 frame held).
  int   m_st, m_ptr, m_owner, m_grant;
  logic m_last, m_send;
  logic [7:0] m_dintx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .send(send), .dintx(dintx), .donetx(donetx),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; donetx = 1'b0; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    donetx = 1'b1;
    tick();
    donetx = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_data[8*i +: 8] = d;
    req_last[i] = l;
  endtask

  task automatic wait_send(input string nm, input int maxc);
    int c;
    c = 0;
    while (send !== 1'b1 && c < maxc) begin
      tick();
      c++;
    end
    chk(nm, send, 1);
  endtask

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
    logic [N-1:0] r;
    bit found;
    r = '0;
    found = 0;
    if (m_st == 0) begin
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_ptr + k) % N]) begin
          r[(m_ptr + k) % N] = 1'b1;
          found = 1;
        end
      end
    end else if (m_st == 2) begin
      r[m_owner] = 1'b1;
    end
    return r;
  endfunction

  task automatic random_phase(input int ncyc);
    bit         hv[N];
    logic [7:0] hd[N];
    logic       hl[N];
    int         tx_cnt, xwho;
    logic       don, pv_send;
    logic [N-1:0] exp_ready;
    m_st = 0; m_ptr = 0; m_owner = 0; m_grant = 0;
    m_last = 0; m_send = 0; m_dintx = 8'h00;
    tx_cnt = 0;
    for (int i = 0; i < N; i++) begin
      hv[i] = 0; hd[i] = 8'h00; hl[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hv[i] && $urandom_range(9) < 6) begin
          hv[i] = 1;
          hd[i] = 8'($urandom_range(255));
          hl[i] = 1'($urandom_range(1));
        end
        req_valid[i] = hv[i];
        req_data[8*i +: 8] = hd[i];
        req_last[i] = hl[i];
      end
      if (tx_cnt > 0) begin
        tx_cnt--;
        donetx = (tx_cnt == 0);
      end else begin
        donetx = ($urandom_range(15) == 0);
      end
      #1;
      exp_ready = model_ready(req_valid);
      chk("rnd_ready", req_ready, exp_ready);
      xwho = -1;
      for (int i = 0; i < N; i++) if (exp_ready[i] && hv[i]) xwho = i;
      don = donetx;
      tick();
      pv_send = m_send;
      m_send  = 1'b0;
      if (m_st == 0) begin
        if (xwho >= 0) begin
          m_owner = xwho; m_last = hl[xwho]; m_dintx = hd[xwho];
          m_send = 1'b1; m_grant = 1 << xwho; m_st = 1;
        end
      end else if (m_st == 1) begin
        if (don && !pv_send) begin
          if (m_last) begin
            m_st = 0; m_grant = 0; m_ptr = (m_owner + 1) % N;
          end else begin
            m_st = 2;
          end
        end
      end else begin
        if (xwho >= 0) begin
          m_last = hl[xwho]; m_dintx = hd[xwho]; m_send = 1'b1; m_st = 1;
        end
      end
      chk("rnd_send", send, m_send);
      chk("rnd_dintx", dintx, m_dintx);
      chk("rnd_grant", grant, m_grant);
      chk("rnd_busy", busy, m_st != 0);
      if (m_send) tx_cnt = $urandom_range(2, 10);
      if (xwho >= 0) hv[xwho] = 0;
    end
    donetx = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    arb_vec_t  avec[6];
    fair_vec_t fvec[5];
    int        early;

    avec[0] = '{4'b0001, 4'b0001};
    avec[1] = '{4'b0110, 4'b0010};
    avec[2] = '{4'b1000, 4'b1000};
    avec[3] = '{4'b1100, 4'b0100};
    avec[4] = '{4'b1111, 4'b0001};
    avec[5] = '{4'b0000, 4'b0000};
    fvec[0] = '{8'h10, 4'b0001};
    fvec[1] = '{8'h11, 4'b0010};
    fvec[2] = '{8'h12, 4'b0100};
    fvec[3] = '{8'h13, 4'b1000};
    fvec[4] = '{8'h10, 4'b0001};

    // Reset state
    rst = 1'b1;
    req_valid = 4'b1111;
    tick();
    chk("rst_ready", req_ready, 0);
    tick();
    chk("rst_send", send, 0);
    chk("rst_dintx", dintx, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_errid", err_id, 0);
    req_valid = '0;
    rst = 1'b0;

    // Idle arbitration from ptr=0
    for (int k = 0; k < 6; k++) begin
      req_valid = avec[k].valid;
      #1;
      chk("tbl_ready", req_ready, avec[k].ready);
    end
    req_valid = '0;
    tick();
    chk("tbl_idle", busy, 0);

    // Single byte from req0
    set_req(0, 8'h55, 1'b1);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_send", send, 1);
    chk("t1_dintx", dintx, 8'h55);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_send_once", send, 0);
    tick();
    pulse_done();
    chk("t1_grant_rel", grant, 0);
    chk("t1_busy_rel", busy, 0);
    req_valid = 4'b1111;
    #1;
    chk("t1_ptr1", req_ready, 4'b0010);
    req_valid = '0;

    // Fairness
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 1'b1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_send("fair_send", 20);
      chk("fair_dintx", dintx, fvec[k].data);
      chk("fair_grant", grant, fvec[k].grant);
      if (k == 4) req_valid = '0;
      tick();
      tick();
      pulse_done();
    end

    // Frame lock
    do_reset();
    set_req(2, 8'hA1, 1'b0);
    req_valid = 4'b0100;
    tick();
    chk("lock_send0", send, 1);
    chk("lock_data0", dintx, 8'hA1);
    chk("lock_grant0", grant, 4'b0100);
    set_req(2, 8'hA2, 1'b0);
    set_req(1, 8'h77, 1'b1);
    req_valid = 4'b0110;
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 3; w++) begin
        #1;
        chk("lock_wait_ready", req_ready, 0);
        tick();
      end
      pulse_done();
      #1;
      chk("lock_hold_ready", req_ready, 4'b0100);
      tick();
      chk("lock_send", send, 1);
      chk("lock_data", dintx, (b == 0) ? 8'hA2 : 8'hA3);
      chk("lock_grant", grant, 4'b0100);
      if (b == 0) set_req(2, 8'hA3, 1'b1);
      else req_valid = 4'b0010;
    end
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("lock_ready1", req_ready[1], 0);
      tick();
    end
    pulse_done();
    #1;
    chk("lock_release", req_ready, 4'b0010);
    tick();
    chk("lock_77", dintx, 8'h77);
    chk("lock_77_grant", grant, 4'b0010);
    req_valid = '0;
    tick();
    pulse_done();

    // Transmitter stuck
    do_reset();
    set_req(3, 8'hE3, 1'b1);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    early = 0;
    for (int k = 1; k <= T; k++) begin
      tick();
      if (k < T && timeout_err !== 1'b0) early++;
    end
    chk("stuck_early", early, 0);
    chk("stuck_pulse", timeout_err, 1);
    chk("stuck_errid", err_id, 3);
    chk("stuck_grant", grant, 0);
    chk("stuck_busy", busy, 0);
    tick();
    chk("stuck_once", timeout_err, 0);
    chk("stuck_errid_hold", err_id, 3);
    req_valid = 4'b1111;
    #1;
    chk("stuck_next_ptr", req_ready, 4'b0001);
    req_valid = '0;

    // Stalled frame
    do_reset();
    set_req(1, 8'hC0, 1'b0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    pulse_done();
    early = 0;
    for (int k = 1; k <= T; k++) begin
      tick();
      if (k < T && (timeout_err !== 1'b0 || grant !== 4'b0010)) early++;
    end
    chk("stall_early", early, 0);
    chk("stall_pulse", timeout_err, 1);
    chk("stall_errid", err_id, 1);
    chk("stall_grant", grant, 0);

    // donetx wins against a same-cycle timeout
    do_reset();
    set_req(0, 8'h5A, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (T - 1) tick();
    donetx = 1'b1;
    tick();
    donetx = 1'b0;
    chk("race_no_err", timeout_err, 0);
    chk("race_idle", busy, 0);

    // Reset in WAIT
    set_req(2, 8'h99, 1'b1);
    req_valid = 4'b0100;
    tick();
    tick();
    chk("rwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rwait_ready_rst", req_ready, 0);
    tick();
    rst = 1'b0;
    chk("rwait_send", send, 0);
    chk("rwait_dintx", dintx, 0);
    chk("rwait_grant", grant, 0);
    chk("rwait_busy0", busy, 0);
    chk("rwait_terr", timeout_err, 0);
    chk("rwait_errid", err_id, 0);
    donetx = 1'b1;
    #1;
    chk("rwait_ready", req_ready, 4'b0100);
    tick();
    donetx = 1'b0;
    req_valid = '0;
    chk("rwait_resend", send, 1);
    chk("rwait_data", dintx, 8'h99);
    chk("rwait_grant2", grant, 4'b0100);
    donetx = 1'b1;
    tick();
    donetx = 1'b0;
    chk("rwait_ignore_send_done", busy, 1);
    tick();
    pulse_done();
    chk("rwait_done", busy, 0);

    // Randomized traffic against the model
    do_reset();
    random_phase(2500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte producers. It sits between the requesters and the `uarttx` instance in the UART top and drives that instance's `send` and `dintx` inputs. It supports multi-byte frames, which lock the grant until the requester marks the last byte. A watchdog aborts a grant if the transmitter never reports completion, or if a locked requester stalls.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `TIMEOUT_CYC`, 4096: watchdog limit in clk cycles. Must exceed one 10-bit frame time (1042 cycles at 1 MHz / 9600 baud).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in 8*NUM_REQ: byte for requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is the final byte of the frame.
- `req_ready` out NUM_REQ: combinational accept. A byte transfers on the edge where `req_valid[i] & req_ready[i]`.
- `send` out 1: one-cycle start pulse to the transmitter.
- `dintx` out 8: byte to the transmitter, held stable from the `send` pulse until `donetx`.
- `donetx` in 1: transmitter one-cycle completion pulse.
- `grant` out NUM_REQ: one-hot current owner; 0 when idle.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.
- `err_id` out $clog2(NUM_REQ): index of the aborted requester, held until the next abort.

## Operation
- Three states: IDLE, WAIT (byte in flight), HOLD (frame locked, waiting for the owner's next byte).
- Round-robin pointer `ptr`; at most one `req_ready` bit is high in any cycle.
- **IDLE**
  - The winner is the first `req_valid` bit scanning ptr, ptr+1, … mod NUM_REQ.
  - `req_ready` is high for the winner only, so an idle arbiter with any valid request accepts a byte every time.
  - On transfer: `dintx`←byte, `send`←1, `grant`←one-hot(winner), latch `req_last`, clear watchdog, go to WAIT.
- **WAIT**
  - `req_ready` is all zero.
  - `donetx` is ignored in the cycle `send` is high.
  - On `donetx` with latched last=1: `grant`←0, `ptr`←(owner+1) mod NUM_REQ, go to IDLE.
  - On `donetx` with latched last=0: go to HOLD and clear the watchdog.
- **HOLD**
  - `req_ready` is high for the owner only; other requesters are blocked.
  - On transfer: same actions as an IDLE transfer, keeping `grant` unchanged, then go to WAIT.
- **Watchdog**
  - Counts every cycle spent in WAIT or HOLD; width $clog2(TIMEOUT_CYC+1), no wrap.
  - When the count reaches TIMEOUT_CYC: `timeout_err`←1 for one cycle, `err_id`←owner index, `grant`←0, `ptr`←owner+1, go to IDLE.
  - A `donetx` arriving in the same cycle as the timeout takes priority; no error is raised.
- A `donetx` pulse arriving in IDLE or HOLD is ignored.
- Arbitration and a transfer both happen in the cycle immediately after returning to IDLE; there is no dead cycle.

## Timing
- Reset (synchronous, effective at the edge where `rst`=1), all outputs:
  - state IDLE, `ptr`=0
  - `send`=0, `dintx`=0x00, `grant`=0, `busy`=0
  - `timeout_err`=0, `err_id`=0, `req_ready`=0 during the `rst` cycle
  - Reset in mid-byte abandons the byte; nothing is reported.
- Latency:
  - Transfer at edge t: `send`=1 and `dintx` valid during cycle t+1; `busy`=1 from t+1.
  - `donetx` at edge d: the next `req_ready` can assert in cycle d+1, and the next `send` follows at d+2 at the earliest.
- `send` is never high in two consecutive cycles.
- `dintx` changes only on transfer edges.

## Test plan
- **Single byte, req0:** req0 valid with 0x55, last=1, all others idle.
  - `send` pulses one cycle, `dintx`=0x55, `grant`=0001.
  - After `donetx`: `grant`=0, `busy`=0, `ptr`=1.
- **Fairness:** all four requesters continuously valid with last=1, bytes 0x10/0x11/0x12/0x13.
  - `dintx` sequence is 0x10, 0x11, 0x12, 0x13, 0x10.
  - `grant` is 0001, 0010, 0100, 1000, 0001.
- **Frame lock:** req2 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while req1 is valid with 0x77.
  - 0x77 is sent only after the `donetx` for 0xA3.
  - `req_ready[1]`=0 throughout the frame.
- **Transmitter stuck:** req3 sends one byte and `donetx` is never pulsed.
  - Exactly TIMEOUT_CYC cycles after the `send` edge, `timeout_err` pulses once with `err_id`=3.
  - Then `grant`=0 and the next arbitration starts at req0.
- **Stalled frame:** req1 sends 0xC0 with last=0, then drops `req_valid`.
  - After `donetx` plus TIMEOUT_CYC cycles in HOLD, `timeout_err` pulses with `err_id`=1 and the grant is released.
- **Reset in WAIT:** assert `rst` for one cycle mid-byte with req2 still valid.
  - Next cycle: all outputs at reset values.
  - Req2 wins again with `ptr`=0 scan and `send` re-pulses.
  - A late `donetx` from the old byte is ignored because the arbiter is not in WAIT.
